// File: rtl/game_sequencer_pkg.sv
// Shared state encoding, parameter defaults and speed helper for the Frog Rank game sequencer.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int LIVES_INIT_DEF = 3;
    localparam int LEVEL_MAX_DEF  = 9;
    localparam int SPEED_BASE_DEF = 1;
    localparam int SPEED_STEP_DEF = 2;
    localparam int HIT_FRAMES_DEF = 60;
    localparam int WIN_FRAMES_DEF = 120;

    localparam int HIT_BLINK_FRAMES  = 8;
    localparam int OVER_BLINK_FRAMES = 32;

    localparam int unsigned SPEED_MAX = 31;

    // Evaluated at 32 bits so large level/step products saturate instead of wrapping.
    function automatic logic [4:0] speed_for_level(input int unsigned lvl,
                                                   input int unsigned base,
                                                   input int unsigned step);
        int unsigned s;
        s = base + (lvl - 1) * step;
        if (s > SPEED_MAX) begin
            s = SPEED_MAX;
        end
        return s[4:0];
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundles the sequencer's frame/collision inputs and its game-status outputs.
// Latency: none (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface game_sequencer_if;

    logic       frame_tick;
    logic       start;
    logic       collision;
    logic       reached_top;

    logic       car_run;
    logic       player_respawn;
    logic [4:0] speed_car;
    logic [3:0] level;
    logic [1:0] lives;
    logic [2:0] game_state;
    logic       flash;

    modport master (
        output frame_tick, start, collision, reached_top,
        input  car_run, player_respawn, speed_car, level, lives, game_state, flash
    );

    modport slave (
        input  frame_tick, start, collision, reached_top,
        output car_run, player_respawn, speed_car, level, lives, game_state, flash
    );

endinterface

// File: rtl/game_sequencer_start_sync.sv
// Synchronises the raw start switch and emits one start event per rising edge seen at a frame tick.
// Latency: 2 cycles of synchroniser, then start_evt is combinational on the next frame_tick.
// Backpressure: none; edges between frame ticks collapse into a single event.
module game_sequencer_start_sync (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic start,
    output logic start_evt
);

    logic start_m;
    logic start_s;
    logic start_prev;

    // start_prev only samples at frame rate, which debounces the switch to one edge per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_m    <= 1'b0;
            start_s    <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            start_m <= start;
            start_s <= start_m;
            if (frame_tick) begin
                start_prev <= start_s;
            end
        end
    end

    assign start_evt = frame_tick & start_s & ~start_prev;

endmodule

// File: rtl/game_sequencer.sv
// Frog Rank game-flow FSM: owns lives, level, car speed, frame timer and flash; gates cars, requests respawn.
// Latency: all outputs registered, one cycle after the triggering input.
// Backpressure: none; inputs are sampled every cycle, frame ticks drive the timer.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int LIVES_INIT = LIVES_INIT_DEF,
    parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
    parameter int SPEED_BASE = SPEED_BASE_DEF,
    parameter int SPEED_STEP = SPEED_STEP_DEF,
    parameter int HIT_FRAMES = HIT_FRAMES_DEF,
    parameter int WIN_FRAMES = WIN_FRAMES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    game_sequencer_if.slave sif
);

    localparam int WAIT_MAX = (HIT_FRAMES > WIN_FRAMES) ? HIT_FRAMES : WIN_FRAMES;
    localparam int CNT_MAX  = (WAIT_MAX > OVER_BLINK_FRAMES) ? WAIT_MAX : OVER_BLINK_FRAMES;
    localparam int TIMER_W  = $clog2(CNT_MAX + 1);

    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
    localparam logic [3:0] LEVEL_TOP = 4'(LEVEL_MAX);
    localparam logic [4:0] SPEED_RST = speed_for_level(1, SPEED_BASE, SPEED_STEP);

    state_t               state_q, state_d;
    logic [1:0]           lives_q, lives_d;
    logic [3:0]           level_q, level_d;
    logic [4:0]           speed_q, speed_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 flash_q, flash_d;
    logic                 car_run_q, car_run_d;
    logic                 respawn_q, respawn_d;

    logic                 start_evt;
    logic [TIMER_W-1:0]   timer_inc;
    logic [3:0]           level_next;
    logic                 hit_blink;

    game_sequencer_start_sync u_start_sync (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (sif.frame_tick),
        .start      (sif.start),
        .start_evt  (start_evt)
    );

    assign timer_inc  = timer_q + 1'b1;
    assign level_next = (level_q >= LEVEL_TOP) ? LEVEL_TOP : level_q + 4'd1;
    assign hit_blink  = (timer_inc & TIMER_W'(HIT_BLINK_FRAMES - 1)) == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Expiry is evaluated on the tick that would bring the timer to its limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_evt) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (sif.collision) begin
                    state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_HIT;
                end else if (sif.reached_top) begin
                    state_d = ST_LEVEL_UP;
                end
            end
            ST_HIT: begin
                if (sif.frame_tick && timer_inc == TIMER_W'(HIT_FRAMES)) state_d = ST_PLAY;
            end
            ST_LEVEL_UP: begin
                if (sif.frame_tick && timer_inc == TIMER_W'(WIN_FRAMES)) state_d = ST_PLAY;
            end
            ST_GAME_OVER: begin
                if (start_evt) state_d = ST_PLAY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lives_d   = lives_q;
        level_d   = level_q;
        speed_d   = speed_q;
        timer_d   = timer_q;
        flash_d   = flash_q;
        car_run_d = (state_d == ST_PLAY);
        respawn_d = (state_d == ST_PLAY) && (state_q != ST_PLAY);
        if (state_d != state_q) begin
            timer_d = '0;
        end
        case (state_q)
            ST_PLAY: begin
                if (sif.collision) begin
                    lives_d = lives_q - 2'd1;
                end else if (sif.reached_top) begin
                    level_d = level_next;
                    speed_d = speed_for_level(32'(level_next), SPEED_BASE, SPEED_STEP);
                    flash_d = 1'b1;
                end
            end
            ST_HIT: begin
                if (state_d == ST_PLAY) begin
                    flash_d = 1'b0;
                end else if (sif.frame_tick) begin
                    timer_d = timer_inc;
                    if (hit_blink) flash_d = ~flash_q;
                end
            end
            ST_LEVEL_UP: begin
                if (state_d == ST_PLAY) begin
                    flash_d = 1'b0;
                end else if (sif.frame_tick) begin
                    timer_d = timer_inc;
                end
            end
            ST_GAME_OVER: begin
                if (state_d == ST_PLAY) begin
                    lives_d = LIVES_RST;
                    level_d = 4'd1;
                    speed_d = SPEED_RST;
                    flash_d = 1'b0;
                end else if (sif.frame_tick) begin
                    // Restart the count at each blink so the timer never wraps while waiting here.
                    if (timer_inc == TIMER_W'(OVER_BLINK_FRAMES)) begin
                        timer_d = '0;
                        flash_d = ~flash_q;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lives_q   <= LIVES_RST;
            level_q   <= 4'd1;
            speed_q   <= SPEED_RST;
            timer_q   <= '0;
            flash_q   <= 1'b0;
            car_run_q <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            lives_q   <= lives_d;
            level_q   <= level_d;
            speed_q   <= speed_d;
            timer_q   <= timer_d;
            flash_q   <= flash_d;
            car_run_q <= car_run_d;
            respawn_q <= respawn_d;
        end
    end

    assign sif.car_run        = car_run_q;
    assign sif.player_respawn = respawn_q;
    assign sif.speed_car      = speed_q;
    assign sif.level          = level_q;
    assign sif.lives          = lives_q;
    assign sif.game_state     = state_q;
    assign sif.flash          = flash_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised scenario bench for game_sequencer against an event-level game model.
module tb_game_sequencer;

    localparam int S_IDLE = 0, S_PLAY = 1, S_HIT = 2, S_LEVEL_UP = 3, S_GAME_OVER = 4;
    localparam int LVL_MAX = 9, LIVES0 = 3, HIT_N = 60, WIN_N = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0, start = 1'b0, collision = 1'b0, reached_top = 1'b0;

    game_sequencer_if sif ();
    game_sequencer_if sif7 ();

    assign sif.frame_tick   = frame_tick;
    assign sif.start        = start;
    assign sif.collision    = collision;
    assign sif.reached_top  = reached_top;
    assign sif7.frame_tick  = frame_tick;
    assign sif7.start       = start;
    assign sif7.collision   = collision;
    assign sif7.reached_top = reached_top;

    game_sequencer dut (.clk(clk), .rst(rst), .sif(sif.slave));
    game_sequencer #(.SPEED_STEP(7)) dut7 (.clk(clk), .rst(rst), .sif(sif7.slave));

    always #5 clk = ~clk;

    int   n_cmp = 0, n_bad = 0;
    int   resp_cnt = 0, resp_double = 0;
    logic resp_prev = 1'b0;
    int   m_state = S_IDLE, m_lives = LIVES0, m_level = 1;

    always @(negedge clk) begin
        if (sif.player_respawn === 1'b1) begin
            resp_cnt++;
            if (resp_prev === 1'b1) resp_double++;
        end
        resp_prev = sif.player_respawn;
    end

    function automatic int exp_speed(input int lvl, input int stp);
        int s;
        s = 1 + (lvl - 1) * stp;
        return (s > 31) ? 31 : s;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {sif.game_state, sif.lives, sif.level, sif.speed_car, sif.car_run, sif.flash};
    endfunction

    function automatic logic [15:0] model_vec(input bit car, input bit fl);
        return {3'(m_state), 2'(m_lives), 4'(m_level), 5'(exp_speed(m_level, 2)), car, fl};
    endfunction

    task automatic step(input bit ft, input bit col, input bit top);
        frame_tick  = ft;
        collision   = col;
        reached_top = top;
        @(posedge clk);
        #1;
        frame_tick  = 1'b0;
        collision   = 1'b0;
        reached_top = 1'b0;
    endtask

    task automatic frames(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) step(1'b0, noise && ($urandom_range(0, 1) == 1), noise && ($urandom_range(0, 1) == 1));
            step(1'b1, noise && ($urandom_range(0, 1) == 1), noise && ($urandom_range(0, 1) == 1));
        end
    endtask

    task automatic set_start(input bit v);
        start = v;
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_state = S_IDLE; m_lives = LIVES0; m_level = 1;
        n_cmp++;
        if (dut_vec() !== model_vec(1'b0, 1'b0)) begin
            n_bad++; $display("FAIL reset_vec: got %h want %h", dut_vec(), model_vec(1'b0, 1'b0));
        end
        n_cmp++;
        if (sif.player_respawn !== 1'b0 || sif7.speed_car !== 5'd1) begin
            n_bad++; $display("FAIL reset_misc: respawn %b speed7 %0d want 0 / 1", sif.player_respawn, sif7.speed_car);
        end
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start();
        int c0;
        c0 = resp_cnt;
        set_start(1'b1);
        step(1'b1, 1'b0, 1'b0);
        m_state = S_PLAY;
        n_cmp++;
        if (dut_vec() !== model_vec(1'b1, 1'b0) || sif.player_respawn !== 1'b1) begin
            n_bad++; $display("FAIL start_play: got %h resp %b want %h resp 1", dut_vec(), sif.player_respawn, model_vec(1'b1, 1'b0));
        end
        frames(4, 1'b0);
        n_cmp++;
        if (resp_cnt - c0 !== 1 || dut_vec() !== model_vec(1'b1, 1'b0)) begin
            n_bad++; $display("FAIL start_once: respawns %0d vec %h want 1 / %h", resp_cnt - c0, dut_vec(), model_vec(1'b1, 1'b0));
        end
        set_start(1'b0);
        frames(1, 1'b0);
    endtask

    task automatic test_hit();
        int c0;
        bit fl;
        frames($urandom_range(0, 4), 1'b0);
        c0 = resp_cnt;
        step($urandom_range(0, 1) == 1, 1'b1, 1'b1);
        m_lives--; m_state = S_HIT;
        n_cmp++;
        if (dut_vec() !== model_vec(1'b0, 1'b0)) begin
            n_bad++; $display("FAIL hit_entry: got %h want %h", dut_vec(), model_vec(1'b0, 1'b0));
        end
        for (int n = 1; n < HIT_N; n++) begin
            frames(1, 1'b1);
            fl = ((n / 8) % 2) == 1;
            n_cmp++;
            if (dut_vec() !== model_vec(1'b0, fl)) begin
                n_bad++; $display("FAIL hit_wait frame %0d: got %h want %h", n, dut_vec(), model_vec(1'b0, fl));
            end
        end
        frames(1, 1'b1);
        m_state = S_PLAY;
        n_cmp++;
        if (dut_vec() !== model_vec(1'b1, 1'b0) || sif.player_respawn !== 1'b1) begin
            n_bad++; $display("FAIL hit_exit: got %h resp %b want %h resp 1", dut_vec(), sif.player_respawn, model_vec(1'b1, 1'b0));
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (resp_cnt - c0 !== 1 || sif.player_respawn !== 1'b0) begin
            n_bad++; $display("FAIL hit_respawn: count %0d now %b want 1 / 0", resp_cnt - c0, sif.player_respawn);
        end
    endtask

    task automatic test_level_up(input int n_ev);
        int c0;
        for (int e = 0; e < n_ev; e++) begin
            frames($urandom_range(0, 3), 1'b0);
            c0 = resp_cnt;
            step($urandom_range(0, 1) == 1, 1'b0, 1'b1);
            m_level = (m_level < LVL_MAX) ? m_level + 1 : LVL_MAX;
            m_state = S_LEVEL_UP;
            n_cmp++;
            if (dut_vec() !== model_vec(1'b0, 1'b1)) begin
                n_bad++; $display("FAIL lvl_entry L%0d: got %h want %h", m_level, dut_vec(), model_vec(1'b0, 1'b1));
            end
            n_cmp++;
            if (sif7.speed_car !== 5'(exp_speed(m_level, 7))) begin
                n_bad++; $display("FAIL lvl_speed_step7 L%0d: got %0d want %0d", m_level, sif7.speed_car, exp_speed(m_level, 7));
            end
            frames(WIN_N - 1, 1'b0);
            n_cmp++;
            if (dut_vec() !== model_vec(1'b0, 1'b1)) begin
                n_bad++; $display("FAIL lvl_wait L%0d: got %h want %h", m_level, dut_vec(), model_vec(1'b0, 1'b1));
            end
            frames(1, 1'b0);
            m_state = S_PLAY;
            n_cmp++;
            if (dut_vec() !== model_vec(1'b1, 1'b0) || sif.player_respawn !== 1'b1) begin
                n_bad++; $display("FAIL lvl_exit L%0d: got %h resp %b want %h resp 1", m_level, dut_vec(), sif.player_respawn, model_vec(1'b1, 1'b0));
            end
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (resp_cnt - c0 !== 1) begin
                n_bad++; $display("FAIL lvl_respawn L%0d: got %0d want 1", m_level, resp_cnt - c0);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        frames(2, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        m_state = S_IDLE; m_lives = LIVES0; m_level = 1;
        n_cmp++;
        if (dut_vec() !== model_vec(1'b0, 1'b0) || sif.player_respawn !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_play: got %h resp %b want %h resp 0", dut_vec(), sif.player_respawn, model_vec(1'b0, 1'b0));
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_game_over();
        int c0;
        bit fl;
        step($urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1);
        m_lives = 0; m_state = S_GAME_OVER;
        n_cmp++;
        if (dut_vec() !== model_vec(1'b0, 1'b0)) begin
            n_bad++; $display("FAIL over_entry: got %h want %h", dut_vec(), model_vec(1'b0, 1'b0));
        end
        for (int n = 1; n <= 70; n++) begin
            frames(1, 1'b0);
            fl = ((n / 32) % 2) == 1;
            n_cmp++;
            if (dut_vec() !== model_vec(1'b0, fl)) begin
                n_bad++; $display("FAIL over_blink frame %0d: got %h want %h", n, dut_vec(), model_vec(1'b0, fl));
            end
        end
        c0 = resp_cnt;
        set_start(1'b1);
        step(1'b1, 1'b0, 1'b0);
        m_state = S_PLAY; m_lives = LIVES0; m_level = 1;
        n_cmp++;
        if (dut_vec() !== model_vec(1'b1, 1'b0) || sif.player_respawn !== 1'b1 || sif7.speed_car !== 5'd1) begin
            n_bad++; $display("FAIL over_restart: got %h resp %b spd7 %0d want %h resp 1 spd7 1", dut_vec(), sif.player_respawn, sif7.speed_car, model_vec(1'b1, 1'b0));
        end
        set_start(1'b0);
        frames(2, 1'b0);
        n_cmp++;
        if (resp_cnt - c0 !== 1) begin
            n_bad++; $display("FAIL over_respawn: got %0d want 1", resp_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        n_cmp++;
        if (resp_double !== 0) begin
            n_bad++; $display("FAIL respawn_back_to_back: got %0d double pulses want 0", resp_double);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_level_up(3);
        test_reset_mid_play();
        test_start();
        test_level_up(9);
        test_hit();
        test_hit();
        test_game_over();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
